// File: rtl/mc_control_fsm.sv
// Multicycle datapath controller: Moore FSM sequencing fetch/decode/execute/mem/wb.
// In: clk, reset (async low), Opcode, Funct, Zero, Overflow. Out: datapath selects/enables, halted, state.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic [1:0] IorD,
  output logic       MemWR,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ALUOutWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       halted,
  output logic [4:0] state
);

  localparam logic [4:0] S_FETCH     = 5'd0;
  localparam logic [4:0] S_FETCH_W   = 5'd1;
  localparam logic [4:0] S_IR_LOAD   = 5'd2;
  localparam logic [4:0] S_DECODE    = 5'd3;
  localparam logic [4:0] S_EXEC_R    = 5'd4;
  localparam logic [4:0] S_WB_R      = 5'd5;
  localparam logic [4:0] S_EXEC_I    = 5'd6;
  localparam logic [4:0] S_WB_I      = 5'd7;
  localparam logic [4:0] S_ADDR      = 5'd8;
  localparam logic [4:0] S_LW_READ   = 5'd9;
  localparam logic [4:0] S_LW_WAIT   = 5'd10;
  localparam logic [4:0] S_LW_MDR    = 5'd11;
  localparam logic [4:0] S_LW_WB     = 5'd12;
  localparam logic [4:0] S_SW_WRITE  = 5'd13;
  localparam logic [4:0] S_BRANCH    = 5'd14;
  localparam logic [4:0] S_JUMP      = 5'd15;
  localparam logic [4:0] S_HALT      = 5'd16;
  localparam logic [4:0] S_ADDM_RD   = 5'd17;
  localparam logic [4:0] S_ADDM_W    = 5'd18;
  localparam logic [4:0] S_ADDM_MDR  = 5'd19;
  localparam logic [4:0] S_ADDM_EXEC = 5'd20;

  logic [4:0] st_q;
  logic [4:0] st_d;
  logic       run_q;

  // Zero only qualifies PCWriteCond inside the datapath.
  logic unused_zero;
  assign unused_zero = Zero;

  logic is_r_fn;
  logic is_alu_r;
  logic is_addm;
  logic is_addi;
  logic is_mem;
  logic is_beq;
  logic is_j;

  assign is_r_fn  = (Funct == 6'h20) || (Funct == 6'h22)
                 || (Funct == 6'h24);
  assign is_alu_r = (Opcode == 6'h00) && is_r_fn;
  assign is_addm  = (Opcode == 6'h00) && (Funct == 6'h05);
  assign is_addi  = (Opcode == 6'h08);
  assign is_mem   = (Opcode == 6'h23) || (Opcode == 6'h2B);
  assign is_beq   = (Opcode == 6'h04);
  assign is_j     = (Opcode == 6'h02);

  // run_q keeps FETCH for the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= S_FETCH;
      run_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    st_d = S_HALT;
    case (st_q)
      S_FETCH:     st_d = run_q ? S_FETCH_W : S_FETCH;
      S_FETCH_W:   st_d = S_IR_LOAD;
      S_IR_LOAD:   st_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_alu_r: st_d = S_EXEC_R;
          is_addm:  st_d = S_ADDM_RD;
          is_addi:  st_d = S_EXEC_I;
          is_mem:   st_d = S_ADDR;
          is_beq:   st_d = S_BRANCH;
          is_j:     st_d = S_JUMP;
          default:  st_d = S_HALT;
        endcase
      end
      S_EXEC_R:
        st_d = (Overflow && Funct != 6'h24)
             ? S_HALT : S_WB_R;
      S_WB_R:      st_d = S_FETCH;
      S_EXEC_I:    st_d = Overflow ? S_HALT : S_WB_I;
      S_WB_I:      st_d = S_FETCH;
      S_ADDR:
        st_d = (Opcode == 6'h23)
             ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:   st_d = S_LW_WAIT;
      S_LW_WAIT:   st_d = S_LW_MDR;
      S_LW_MDR:    st_d = S_LW_WB;
      S_LW_WB:     st_d = S_FETCH;
      S_SW_WRITE:  st_d = S_FETCH;
      S_BRANCH:    st_d = S_FETCH;
      S_JUMP:      st_d = S_FETCH;
      S_HALT:      st_d = S_HALT;
      S_ADDM_RD:   st_d = S_ADDM_W;
      S_ADDM_W:    st_d = S_ADDM_MDR;
      S_ADDM_MDR:  st_d = S_ADDM_EXEC;
      S_ADDM_EXEC: st_d = Overflow ? S_HALT : S_WB_R;
      default:     st_d = S_HALT;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 2'b00;
    MemWR       = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    ALUOutWrite = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    halted      = 1'b0;
    case (st_q)
      S_FETCH, S_FETCH_W: begin
        ALUSrcB = 2'b01;
        ALUOp   = 3'b001;
      end
      S_IR_LOAD: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b001;
      end
      S_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUOutWrite = 1'b1;
        ALUSrcB     = 2'b11;
        ALUOp       = 3'b001;
      end
      S_EXEC_R: begin
        ALUSrcA     = 2'b01;
        ALUOutWrite = 1'b1;
        case (Funct)
          6'h22:   ALUOp = 3'b010;
          6'h24:   ALUOp = 3'b011;
          default: ALUOp = 3'b001;
        endcase
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
      end
      S_WB_I:      RegWrite = 1'b1;
      S_LW_READ, S_LW_WAIT: IorD = 2'b01;
      S_LW_MDR: begin
        IorD     = 2'b01;
        MDRWrite = 1'b1;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_SW_WRITE: begin
        IorD  = 2'b01;
        MemWR = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 3'b010;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_HALT:      halted = 1'b1;
      S_ADDM_RD, S_ADDM_W: IorD = 2'b10;
      S_ADDM_MDR: begin
        IorD     = 2'b10;
        MDRWrite = 1'b1;
      end
      S_ADDM_EXEC: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = st_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction-stream bench for mc_control_fsm.
// Expected state traces and control vectors come from a per-instruction model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       Overflow = 1'b0;
  logic       PCWrite, PCWriteCond, MemWR, IRWrite;
  logic       MDRWrite, AWrite, BWrite, ALUOutWrite;
  logic       RegWrite, RegDst, MemToReg, halted;
  logic [1:0] PCSource, IorD, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [4:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset(reset),
    .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .Overflow(Overflow),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IorD(IorD), .MemWR(MemWR),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite),
    .AWrite(AWrite), .BWrite(BWrite),
    .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  logic [22:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, PCSource, IorD,
                MemWR, IRWrite, MDRWrite, AWrite, BWrite,
                ALUOutWrite, RegWrite, RegDst, MemToReg,
                ALUSrcA, ALUSrcB, ALUOp, halted};

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Control vector a state must show, straight from the state table.
  function automatic logic [22:0] exp_ctl(input int st,
                                          input logic [5:0] fn);
    logic pw, pwc, mw, irw, mdrw, aw, bw, aow, rw, rd, m2r, h;
    logic [1:0] ps, iod, sa, sb;
    logic [2:0] op;
    {pw, pwc, mw, irw, mdrw, aw, bw, aow, rw, rd, m2r, h} = '0;
    ps = 0; iod = 0; sa = 0; sb = 0; op = 0;
    case (st)
      0, 1: begin sb = 1; op = 1; end
      2: begin irw = 1; pw = 1; sb = 1; op = 1; end
      3: begin aw = 1; bw = 1; aow = 1; sb = 3; op = 1; end
      4: begin
        sa = 1; aow = 1;
        op = (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd1;
      end
      5: begin rw = 1; rd = 1; end
      6, 8: begin sa = 1; sb = 2; op = 1; aow = 1; end
      7: rw = 1;
      9, 10: iod = 1;
      11: begin iod = 1; mdrw = 1; end
      12: begin rw = 1; m2r = 1; end
      13: begin iod = 1; mw = 1; end
      14: begin sa = 1; op = 2; pwc = 1; ps = 1; end
      15: begin pw = 1; ps = 2; end
      16: h = 1;
      17, 18: iod = 2;
      19: begin iod = 2; mdrw = 1; end
      20: begin sa = 2; op = 1; aow = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mw, irw, mdrw, aw, bw,
            aow, rw, rd, m2r, sa, sb, op, h};
  endfunction

  // States visited after FETCH for one instruction.
  function automatic void trace(input logic [5:0] op,
                                input logic [5:0] fn,
                                input logic ovf,
                                output int q[$]);
    q = {1, 2, 3};
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      q.push_back(4);
      q.push_back((ovf && fn != 6'h24) ? 16 : 5);
    end else if (op == 6'h00 && fn == 6'h05) begin
      q = {q, 17, 18, 19, 20};
      q.push_back(ovf ? 16 : 5);
    end else if (op == 6'h08) begin
      q.push_back(6);
      q.push_back(ovf ? 16 : 7);
    end else if (op == 6'h23) q = {q, 8, 9, 10, 11, 12};
    else if (op == 6'h2B) q = {q, 8, 13};
    else if (op == 6'h04) q.push_back(14);
    else if (op == 6'h02) q.push_back(15);
    else q.push_back(16);
    if (q[$] != 16) q.push_back(0);
  endfunction

  task automatic chk_state(input string tag, input int st);
    check({tag, "_st"}, 32'(state), 32'(st));
    check($sformatf("%s_ctl_s%0d", tag, st),
          32'(ctl), 32'(exp_ctl(st, Funct)));
  endtask

  // Async assert off-edge, then release; FETCH holds one edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk_state("rst_async", 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_state("rst_hold", 0);
  endtask

  // Expects to start #1 after an edge in FETCH; abort_at<0 runs to the end.
  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn,
                           input logic ovf,
                           input int abort_at);
    int q[$];
    string tag;
    Opcode = op; Funct = fn; Overflow = ovf;
    Zero = 1'($urandom);
    trace(op, fn, ovf, q);
    tag = $sformatf("op%0h_fn%0h_v%0d", op, fn, ovf);
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
      chk_state(tag, q[i]);
    end
    if (q[$] == 16) begin
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        chk_state({tag, "_halt"}, 16);
      end
      do_reset();
    end
  endtask

  logic [5:0] ops [8];
  logic [5:0] fns [5];

  initial begin
    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h05, 6'h3A};
    #2;
    do_reset();
    run_instr(6'h00, 6'h22, 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b1, -1);
    run_instr(6'h00, 6'h05, 1'b0, -1);
    run_instr(6'h08, 6'h00, 1'b1, -1);
    run_instr(6'h04, 6'h00, 1'b0, -1);
    run_instr(6'h00, 6'h24, 1'b1, -1);
    run_instr(6'h3F, 6'h00, 1'b0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 6);
    run_instr(6'h2B, 6'h00, 1'b1, -1);
    run_instr(6'h02, 6'h00, 1'b0, -1);
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 7)];
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0)
                  ? int'($urandom_range(1, 4)) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
